// File: rtl/can_mux_bus_slave_if.sv
// Multiplexed 8051-style host bus plus the register-file strobe side.
// slave: the bus responder; master: host pads and register file.
interface can_mux_bus_slave_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cs_can_i;
  logic          ale_i;
  logic          rd_i;
  logic          wr_i;
  logic [DW-1:0] port_i;
  logic [DW-1:0] port_o;
  logic          port_oe_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          we_o;
  logic          re_o;
  logic [DW-1:0] rdata_i;
  logic          busy_o;
  logic          err_o;

  modport slave (
    input  cs_can_i, ale_i, rd_i, wr_i, port_i, rdata_i,
    output port_o, port_oe_o, addr_o, wdata_o,
    output we_o, re_o, busy_o, err_o
  );

  modport master (
    output cs_can_i, ale_i, rd_i, wr_i, port_i, rdata_i,
    input  port_o, port_oe_o, addr_o, wdata_o,
    input  we_o, re_o, busy_o, err_o
  );
endinterface

// File: rtl/can_mux_bus_slave.sv
// Multiplexed host bus responder producing one-cycle register strobes.
// Define CAN_BUS_SYNC_EN to put 2-flop synchronizers on the bus inputs.
module can_mux_bus_slave #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  can_mux_bus_slave_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic          cs;
  logic          ale;
  logic          rd;
  logic          wr;
  logic [DW-1:0] pd;

`ifdef CAN_BUS_SYNC_EN
  logic [DW+3:0] sync1;
  logic [DW+3:0] sync2;

  // two-stage synchronizer ahead of the bus view
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.cs_can_i, bus.ale_i, bus.rd_i,
                bus.wr_i, bus.port_i};
      sync2 <= sync1;
    end
  end

  assign {cs, ale, rd, wr, pd} = sync2;
`else
  assign cs  = bus.cs_can_i;
  assign ale = bus.ale_i;
  assign rd  = bus.rd_i;
  assign wr  = bus.wr_i;
  assign pd  = bus.port_i;
`endif

  logic [2:0]    state;
  logic [7:0]    cnt;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] port_r;
  logic          we_r;
  logic          re_r;
  logic          err_r;

  // Each state is only entered with its strobe seen high, so a
  // low level inside ADDR/WRITE/READ is the falling edge itself.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      port_r  <= '0;
      we_r    <= 1'b0;
      re_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      we_r  <= 1'b0;
      re_r  <= 1'b0;
      err_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cs && ale) begin
            state  <= S_ADDR;
            addr_r <= pd[AW-1:0];
          end
        end
        S_ADDR: begin
          port_r <= rdata_q();
          if (!cs) begin
            state <= S_IDLE;
            err_r <= 1'b1;
          end else if (ale) begin
            addr_r <= pd[AW-1:0];
          end else begin
            cnt <= '0;
            if (wr) begin
              state   <= S_WRITE;
              wdata_r <= pd;
              err_r   <= rd;
            end else if (rd) begin
              state <= S_READ;
              re_r  <= 1'b1;
            end else begin
              state <= S_CMD;
            end
          end
        end
        S_CMD: begin
          port_r <= rdata_q();
          if (!cs) begin
            state <= S_IDLE;
            err_r <= 1'b1;
          end else if (wr) begin
            state   <= S_WRITE;
            wdata_r <= pd;
            err_r   <= rd;
          end else if (rd) begin
            state <= S_READ;
            re_r  <= 1'b1;
          end else if (ale) begin
            state  <= S_ADDR;
            addr_r <= pd[AW-1:0];
          end else if (cnt == TO_LAST) begin
            state <= S_IDLE;
            err_r <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WRITE: begin
          if (!wr) begin
            state <= S_IDLE;
            we_r  <= 1'b1;
          end else if (!cs) begin
            state <= S_IDLE;
            err_r <= 1'b1;
          end else begin
            wdata_r <= pd;
          end
        end
        S_READ: begin
          port_r <= rdata_q();
          if (!rd || !cs) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  function automatic logic [DW-1:0] rdata_q();
    return bus.rdata_i;
  endfunction

  // drive the pad only while the host is actually reading
  always_comb begin
    bus.port_oe_o = 1'b0;
    unique case (state)
      S_CMD:   bus.port_oe_o = cs & rd & ~wr;
      S_READ:  bus.port_oe_o = cs & rd;
      default: bus.port_oe_o = 1'b0;
    endcase
  end

  assign bus.port_o  = port_r;
  assign bus.addr_o  = addr_r;
  assign bus.wdata_o = wdata_r;
  assign bus.we_o    = we_r;
  assign bus.re_o    = re_r;
  assign bus.err_o   = err_r;
  assign bus.busy_o  = (state != S_IDLE);

endmodule

// File: tb/tb_can_mux_bus_slave.sv
// Directed and random host transactions checked against a
// transaction-level model of the multiplexed bus responder.
module tb_can_mux_bus_slave;

`ifdef CAN_BUS_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int HOLD    = (LAT > 0) ? 3 : 1;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  can_mux_bus_slave_if #(.AW(8), .DW(8)) bus_if ();

  can_mux_bus_slave #(
    .AW(8), .DW(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus_if.slave)
  );

  logic [7:0] regs [256];
  assign bus_if.rdata_i = regs[bus_if.addr_o];

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int we_n   = 0;
  int re_n   = 0;
  int err_n  = 0;
  int both_n = 0;
  int we_cyc = 0;
  int err_cyc  = 0;
  int fall_cyc = 0;
  logic [7:0] we_a = 8'h00;
  logic [7:0] we_d = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.we_o) begin
      we_n++;
      we_a   = bus_if.addr_o;
      we_d   = bus_if.wdata_o;
      we_cyc = cyc;
    end
    if (bus_if.re_o) re_n++;
    if (bus_if.err_o) begin
      err_n++;
      err_cyc = cyc;
    end
    if (bus_if.we_o && bus_if.re_o) both_n++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d,
                           input int h, input bit with_rd,
                           input bit abort);
    bus_if.cs_can_i = 1'b1;
    bus_if.ale_i    = 1'b1;
    bus_if.port_i   = a;
    tick(h);
    bus_if.ale_i  = 1'b0;
    bus_if.wr_i   = 1'b1;
    bus_if.rd_i   = with_rd;
    bus_if.port_i = d;
    tick(h);
    if (abort) begin
      bus_if.cs_can_i = 1'b0;
      bus_if.port_i   = 8'($urandom);
      tick(h);
    end
    bus_if.cs_can_i = 1'b0;
    bus_if.wr_i     = 1'b0;
    bus_if.rd_i     = 1'b0;
    bus_if.port_i   = 8'($urandom);
    fall_cyc = cyc;
    tick(LAT + 3);
  endtask

  task automatic check_write(input logic [7:0] a, input logic [7:0] d,
                             input int we0, input int err0,
                             input int exp_err);
    chk("we_count", we_n - we0, 1);
    chk("we_addr", we_a, a);
    chk("we_data", we_d, d);
    chk("wr_err", err_n - err0, exp_err);
    chk("wr_busy", bus_if.busy_o, 0);
    regs[a] = d;
  endtask

  task automatic bus_read(input logic [7:0] a, input int h);
    int re0  = re_n;
    int err0 = err_n;
    bus_if.cs_can_i = 1'b1;
    bus_if.ale_i    = 1'b1;
    bus_if.port_i   = a;
    tick(h);
    bus_if.ale_i  = 1'b0;
    bus_if.port_i = 8'($urandom);
    tick(h);
    bus_if.rd_i = 1'b1;
    if (h > 1) tick(h - 1);
    #1;
    chk("rd_oe", bus_if.port_oe_o, 1);
    chk("rd_data", bus_if.port_o, regs[a]);
    tick(1);
    bus_if.rd_i = 1'b0;
    if (LAT > 0) tick(LAT);
    #1;
    chk("rd_oe_off", bus_if.port_oe_o, 0);
    bus_if.cs_can_i = 1'b0;
    tick(LAT + 3);
    chk("re_count", re_n - re0, 1);
    chk("rd_err", err_n - err0, 0);
    chk("rd_busy", bus_if.busy_o, 0);
  endtask

  initial begin
    int we0;
    int re0;
    int err0;
    int h;
    logic [7:0] ra;
    logic [7:0] rdat;

    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
    bus_if.cs_can_i = 1'b0;
    bus_if.ale_i    = 1'b0;
    bus_if.rd_i     = 1'b0;
    bus_if.wr_i     = 1'b0;
    bus_if.port_i   = 8'h00;

    tick(3);
    chk("rst_addr", bus_if.addr_o, 0);
    chk("rst_wdata", bus_if.wdata_o, 0);
    chk("rst_port", bus_if.port_o, 0);
    chk("rst_oe", bus_if.port_oe_o, 0);
    chk("rst_we", bus_if.we_o, 0);
    chk("rst_re", bus_if.re_o, 0);
    chk("rst_busy", bus_if.busy_o, 0);
    chk("rst_err", bus_if.err_o, 0);
    rst_n = 1'b1;
    tick(2);

    we0 = we_n; err0 = err_n;
    bus_write(8'h06, 8'h41, HOLD, 1'b0, 1'b0);
    check_write(8'h06, 8'h41, we0, err0, 0);
    chk("wr_lat", we_cyc - fall_cyc, 1 + LAT);

    regs[8'h02] = 8'h0C;
    bus_read(8'h02, HOLD);

    we0 = we_n; re0 = re_n; err0 = err_n;
    bus_if.cs_can_i = 1'b1;
    bus_if.ale_i    = 1'b1;
    bus_if.port_i   = 8'h01;
    tick(HOLD);
    bus_if.ale_i = 1'b0;
    fall_cyc = cyc;
    tick(LAT + TIMEOUT + 4);
    chk("to_err_count", err_n - err0, 1);
    chk("to_err_cycle", err_cyc - fall_cyc, 1 + LAT + TIMEOUT);
    chk("to_busy", bus_if.busy_o, 0);
    chk("to_no_we", we_n - we0, 0);
    chk("to_no_re", re_n - re0, 0);
    bus_if.cs_can_i = 1'b0;
    tick(2);

    we0 = we_n; err0 = err_n;
    bus_write(8'h10, 8'h55, HOLD, 1'b0, 1'b1);
    chk("abort_no_we", we_n - we0, 0);
    chk("abort_err", err_n - err0, 1);
    chk("abort_busy", bus_if.busy_o, 0);

    we0 = we_n; err0 = err_n;
    bus_write(8'h20, 8'h66, HOLD, 1'b1, 1'b0);
    check_write(8'h20, 8'h66, we0, err0, 1);

    we0 = we_n;
    bus_if.cs_can_i = 1'b1;
    bus_if.ale_i    = 1'b1;
    bus_if.port_i   = 8'h3C;
    tick(HOLD);
    bus_if.ale_i  = 1'b0;
    bus_if.wr_i   = 1'b1;
    bus_if.port_i = 8'hA5;
    tick(LAT + 2);
    chk("pre_rst_busy", bus_if.busy_o, 1);
    chk("pre_rst_wdata", bus_if.wdata_o, 8'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", bus_if.addr_o, 0);
    chk("mid_rst_wdata", bus_if.wdata_o, 0);
    chk("mid_rst_busy", bus_if.busy_o, 0);
    chk("mid_rst_we", bus_if.we_o, 0);
    chk("mid_rst_oe", bus_if.port_oe_o, 0);
    bus_if.cs_can_i = 1'b0;
    bus_if.wr_i     = 1'b0;
    bus_if.port_i   = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(LAT + 2);
    chk("rst_no_we", we_n - we0, 0);
    we0 = we_n; err0 = err_n;
    bus_write(8'h00, 8'h01, HOLD, 1'b0, 1'b0);
    check_write(8'h00, 8'h01, we0, err0, 0);

    we0 = we_n; err0 = err_n;
    bus_write(8'h1F, 8'h87, 3, 1'b0, 1'b0);
    check_write(8'h1F, 8'h87, we0, err0, 0);
    chk("sync_wr_lat", we_cyc - fall_cyc, 1 + LAT);

    for (int i = 0; i < 24; i++) begin
      ra   = 8'($urandom);
      rdat = 8'($urandom);
      h    = HOLD + int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        we0 = we_n; err0 = err_n;
        bus_write(ra, rdat, h, 1'b0, 1'b0);
        check_write(ra, rdat, we0, err0, 0);
      end else begin
        bus_read(ra, h);
      end
    end

    chk("we_re_overlap", both_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/can_mux_bus_slave.md
Name: can_mux_bus_slave

Overview:
- Responder for the 8051-style multiplexed legacy host bus (cs/ale/rd/wr, shared 8-bit port) used by can_top.
- Latches the address on ALE and converts rd/wr pulses into single-cycle register strobes toward can_registers.
- Drives read data back onto the port, with a separate output enable for an external tri-state buffer.
- Sits between the port_0_io pad logic and the register file; replaces the ad hoc legacy decoding.

Parameters:
- AW, 8, register address width (port bits used for address).
- DW, 8, data width; must equal the port width.
- TIMEOUT, 16, clk_i cycles allowed in CMD state before abort; range 2..255.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-low
- cs_can_i  in  1  chip select, active-high
- ale_i  in  1  address latch enable, active-high
- rd_i  in  1  read strobe, active-high
- wr_i  in  1  write strobe, active-high
- port_i  in  DW  port_0 input (address or write data)
- port_o  out  DW  read data to port_0
- port_oe_o  out  1  port_0 output enable
- addr_o  out  AW  latched register address
- wdata_o  out  DW  write data
- we_o  out  1  one-cycle write strobe
- re_o  out  1  one-cycle read strobe (for read-to-clear registers)
- rdata_i  in  DW  combinational register read data for addr_o
- busy_o  out  1  high in any state except IDLE
- err_o  out  1  one-cycle pulse on timeout or protocol abort

Behaviour:
- Reset (rst_i=0, async): state=IDLE; addr_o=0, wdata_o=0, port_o=0, port_oe_o=0, we_o=0, re_o=0, busy_o=0, err_o=0, timeout counter=0.
- Signals below are the "bus view": raw inputs, or their synchronized versions (see Optional Feature). Edges are detected against the previous-cycle bus view.
- FSM states: IDLE, ADDR, CMD, WRITE, READ.
  - IDLE -> ADDR when cs&ale.
  - ADDR: addr_o <= port_i every cycle; when ale falls with cs high -> CMD, counter cleared.
  - CMD: counter increments.
    - wr&cs -> WRITE.
    - rd&cs -> READ; re_o=1 on the entry cycle.
    - ale&cs -> ADDR (re-address).
    - counter reaches TIMEOUT-1 -> IDLE with err_o pulse.
  - WRITE: wdata_o <= port_i every cycle wr is high. On wr fall: we_o=1 for exactly one cycle, addr_o/wdata_o stable during it -> IDLE.
  - READ: port_oe_o=1 while rd&cs; port_o <= rdata_i every cycle in CMD and READ, so data is valid in the first rd cycle. rd fall -> IDLE, port_oe_o=0 the same cycle.
- Simultaneous wr fall and cs fall: write still commits using data sampled in the previous cycle.
- cs falls while wr still high, or cs falls in ADDR/CMD: abort to IDLE, no we_o, err_o=1.
- rd and wr high together in CMD: wr wins, err_o=1; the write completes normally.
- ale asserted during WRITE/READ: ignored until IDLE.
- we_o and re_o are never high in the same cycle. At most one we_o per ALE cycle.
- Reset mid-transaction: immediate return to IDLE, all strobes 0.

Optional Feature:
- CAN_BUS_SYNC_EN defined:
  - cs_can_i/ale_i/rd_i/wr_i/port_i pass through 2-flop synchronizers before the bus view.
  - All responses are delayed 2 cycles; the host must hold strobes at least 3 clk_i cycles.
  - port_oe_o is taken from the synchronized rd&cs.
- Undefined: the bus is synchronous to clk_i and inputs are used directly; one-cycle strobes are legal.

Test Plan:
- Write, no sync: cs+ale with port=0x06 (1 cycle), then wr with port=0x41 (1 cycle), then cs and wr low together -> exactly one we_o pulse with addr_o=0x06, wdata_o=0x41; err_o stays 0.
- Read: ale addr 0x02, rd 1 cycle, rdata_i=0x0C -> re_o pulses once on rd entry; port_oe_o=1 and port_o=0x0C during rd; port_oe_o=0 after rd falls.
- Timeout: ale addr 0x01, then no rd/wr for 16 cycles -> err_o pulses once at cycle 16, busy_o=0 afterward, no we_o/re_o.
- Abort: cs drops while wr is still high -> no we_o, err_o=1, state IDLE.
- Async reset asserted during WRITE -> all outputs 0 immediately; the next valid write to 0x00 with data 0x01 completes normally.
- CAN_BUS_SYNC_EN: write with 3-cycle strobes to 0x1F with data 0x87 -> we_o occurs 2 cycles after wr falls, addr_o=0x1F, wdata_o=0x87.
